// File: rtl/nios2_qsys_nios2_cpu_mul_seq.sv
// Sequential 32x32 -> 32 (low word) unsigned multiplier built from one shared
// 16x16 multiplier with MUL_LATENCY pipeline stages. The upper partial
// product A_hi*B_hi never reaches the low 32 bits, so it is never issued.
module nios2_qsys_nios2_cpu_mul_seq #(
  parameter int unsigned MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        stall,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_P1,
    S_P2,
    S_P3,
    S_WAIT,
    S_DONE
  } state_e;

  // Identifies which partial product occupies a multiplier stage
  typedef enum logic [1:0] {
    T_NONE,
    T_P1,
    T_P2,
    T_P3
  } tag_e;

  localparam logic [1:0] WAIT_INIT = 2'(MUL_LATENCY - 1);

  state_e      state_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [1:0]  cnt_q;
  logic [31:0] acc_q;
  logic [31:0] result_q;
  logic        busy_q;
  logic        done_q;

  logic [15:0] op_a;
  logic [15:0] op_b;
  tag_e        issue_tag;

  logic [31:0] prod_q [MUL_LATENCY];
  tag_e        tag_q  [MUL_LATENCY];

  logic [31:0] prod_out;
  tag_e        tag_out;
  logic [31:0] acc_add;

  // Select the operand halves for the partial product issued this cycle
  always_comb begin
    op_a      = '0;
    op_b      = '0;
    issue_tag = T_NONE;
    case (state_q)
      S_P1: begin
        op_a      = a_q[15:0];
        op_b      = b_q[15:0];
        issue_tag = T_P1;
      end
      S_P2: begin
        op_a      = a_q[15:0];
        op_b      = b_q[31:16];
        issue_tag = T_P2;
      end
      S_P3: begin
        op_a      = a_q[31:16];
        op_b      = b_q[15:0];
        issue_tag = T_P3;
      end
      default: begin
        op_a      = '0;
        op_b      = '0;
        issue_tag = T_NONE;
      end
    endcase
  end

  // Shared 16x16 multiplier pipeline; tags travel with products so the
  // accumulator knows how to combine whatever emerges from the last stage
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      for (int unsigned i = 0; i < MUL_LATENCY; i++) begin
        prod_q[i] <= '0;
        tag_q[i]  <= T_NONE;
      end
    end else if (!stall) begin
      prod_q[0] <= {16'h0, op_a} * {16'h0, op_b};
      tag_q[0]  <= issue_tag;
      for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
        prod_q[i] <= prod_q[i-1];
        tag_q[i]  <= tag_q[i-1];
      end
    end
  end

  // Output of the last stage and the shifted cross-term sum
  always_comb begin
    prod_out = prod_q[MUL_LATENCY-1];
    tag_out  = tag_q[MUL_LATENCY-1];
    acc_add  = acc_q + {prod_out[15:0], 16'h0};
  end

  // Sequencer FSM, accumulator and registered outputs. The P3 product
  // emerges in the last WAIT cycle, so result is loaded on the same edge
  // that enters DONE and never exposes partial sums.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (flush) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (!stall) begin
      case (tag_out)
        T_P1: acc_q <= prod_out;
        T_P2: acc_q <= acc_add;
        T_P3: begin
          acc_q    <= acc_add;
          result_q <= acc_add;
        end
        default: ;
      endcase

      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_q     <= src1;
            b_q     <= src2;
            state_q <= S_P1;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          done_q <= 1'b0;
        end
        S_P1: state_q <= S_P2;
        S_P2: state_q <= S_P3;
        S_P3: begin
          state_q <= S_WAIT;
          cnt_q   <= WAIT_INIT;
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_nios2_qsys_nios2_cpu_mul_seq.sv
// Self-checking bench for the sequential multiplier: directed scenarios plus
// a randomized run against a cycle-count reference model, for latencies 1 and 2.
module tb_nios2_qsys_nios2_cpu_mul_seq;

  logic        clk = 1'b0;
  logic        reset_n, start, stall, flush;
  logic [31:0] src1, src2;
  logic        busy1, done1, busy2, done2;
  logic [31:0] result1, result2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nios2_qsys_nios2_cpu_mul_seq #(.MUL_LATENCY(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .src1(src1), .src2(src2),
    .stall(stall), .flush(flush), .busy(busy1), .done(done1), .result(result1)
  );

  nios2_qsys_nios2_cpu_mul_seq #(.MUL_LATENCY(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start(start), .src1(src1), .src2(src2),
    .stall(stall), .flush(flush), .busy(busy2), .done(done2), .result(result2)
  );

  // Reference model: k counts unstalled cycles since accept (0 = idle).
  // Busy while 1..3+L, done at 4+L, result = low word of the product.
  int          m_k   [2] = '{0, 0};
  logic [31:0] m_prod[2] = '{32'h0, 32'h0};
  logic [31:0] m_res [2] = '{32'h0, 32'h0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        m_k[i]   = 0;
        m_res[i] = 32'h0;
      end else if (flush) begin
        m_k[i] = 0;
      end else if (!stall) begin
        if (m_k[i] == 0 || m_k[i] == 5 + i) begin
          if (start) begin
            m_k[i]    = 1;
            m_prod[i] = src1 * src2;
          end else begin
            m_k[i] = 0;
          end
        end else begin
          m_k[i] = m_k[i] + 1;
          if (m_k[i] == 5 + i) m_res[i] = m_prod[i];
        end
      end
    end
  end

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return {16'h0, 16'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  task automatic do_reset();
    reset_n = 1'b0; start = 1'b0; stall = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b1; src1 = 32'h5; src2 = 32'h7;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy1, done1, result1} !== 34'h0)
      $display("FAIL reset_l1: got busy=%b done=%b result=%h, expected 0/0/00000000", busy1, done1, result1);
    checks++;
    if ({busy2, done2, result2} !== 34'h0)
      $display("FAIL reset_l2: got busy=%b done=%b result=%h, expected 0/0/00000000", busy2, done2, result2);
    if ({busy1, done1, result1} !== 34'h0 || {busy2, done2, result2} !== 34'h0) errors++;
    reset_n = 1'b1; start = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy1, done1, result1, busy2, done2, result2} !== 68'h0) begin
      errors++;
      $display("FAIL reset_release: got l1 %b/%b/%h l2 %b/%b/%h, expected all zero", busy1, done1, result1, busy2, done2, result2);
    end
  endtask

  task automatic test_basic();
    do_reset();
    src1 = 32'h00010002; src2 = 32'h00030004; start = 1'b1;
    @(negedge clk);
    start = 1'b0; src1 = $urandom; src2 = $urandom;
    for (int c = 1; c <= 6; c++) begin
      checks++;
      if (busy1 !== (c <= 4) || done1 !== (c == 5)) begin
        errors++;
        $display("FAIL basic_timing_l1 c=%0d: got busy=%b done=%b, expected busy=%b done=%b", c, busy1, done1, c <= 4, c == 5);
      end
      checks++;
      if (busy2 !== (c <= 5) || done2 !== (c == 6)) begin
        errors++;
        $display("FAIL basic_timing_l2 c=%0d: got busy=%b done=%b, expected busy=%b done=%b", c, busy2, done2, c <= 5, c == 6);
      end
      if (c <= 4) begin
        checks++;
        if (result1 !== 32'h0) begin
          errors++;
          $display("FAIL basic_no_partial c=%0d: got result=%h, expected 00000000", c, result1);
        end
      end
      if (c >= 5) begin
        checks++;
        if (result1 !== 32'h000A0008) begin
          errors++;
          $display("FAIL basic_result_l1 c=%0d: got %h, expected 000a0008", c, result1);
        end
      end
      if (c == 6) begin
        checks++;
        if (result2 !== 32'h000A0008) begin
          errors++;
          $display("FAIL basic_result_l2: got %h, expected 000a0008", result2);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_corners();
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [31:0] ve [3];
    va[0] = 32'hFFFFFFFF; vb[0] = 32'hFFFFFFFF; ve[0] = 32'h00000001;
    va[1] = 32'h12345678; vb[1] = 32'h0;        ve[1] = 32'h0;
    va[2] = $urandom;     vb[2] = $urandom;     ve[2] = va[2] * vb[2];
    for (int n = 0; n < 3; n++) begin
      src1 = va[n]; src2 = vb[n]; start = 1'b1;
      @(negedge clk);
      start = 1'b0; src1 = ~va[n]; src2 = ~vb[n];
      repeat (4) @(negedge clk);
      checks++;
      if (done1 !== 1'b1 || result1 !== ve[n]) begin
        errors++;
        $display("FAIL corner%0d %h*%h: got done=%b result=%h, expected done=1 result=%h", n, va[n], vb[n], done1, result1, ve[n]);
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_stall();
    do_reset();
    src1 = 32'h00010002; src2 = 32'h00030004; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    stall = 1'b1;
    for (int c = 3; c <= 11; c++) begin
      @(negedge clk);
      checks++;
      if (busy1 !== (c <= 7) || done1 !== (c >= 8 && c <= 10)) begin
        errors++;
        $display("FAIL stall_timing c=%0d: got busy=%b done=%b, expected busy=%b done=%b", c, busy1, done1, c <= 7, c >= 8 && c <= 10);
      end
      if (c >= 8) begin
        checks++;
        if (result1 !== 32'h000A0008) begin
          errors++;
          $display("FAIL stall_result c=%0d: got %h, expected 000a0008", c, result1);
        end
      end
      if (c == 5 || c == 10) stall = 1'b0;
      if (c == 8) stall = 1'b1;
    end
  endtask

  task automatic test_flush();
    do_reset();
    src1 = 32'h00010002; src2 = 32'h00030004; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    src1 = 32'hDEADBEEF; src2 = 32'h00001234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || busy2 !== 1'b0 || result1 !== 32'h000A0008) begin
      errors++;
      $display("FAIL flush_abort: got busy1=%b done1=%b busy2=%b result=%h, expected 0/0/0/000a0008", busy1, done1, busy2, result1);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (done1 !== 1'b0 || done2 !== 1'b0 || result1 !== 32'h000A0008) begin
        errors++;
        $display("FAIL flush_quiet c=%0d: got done1=%b done2=%b result=%h, expected 0/0/000a0008", c, done1, done2, result1);
      end
    end
    src1 = 32'h2; src2 = 32'h3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (done1 !== 1'b1 || result1 !== 32'h00000006) begin
      errors++;
      $display("FAIL flush_restart: got done=%b result=%h, expected done=1 result=00000006", done1, result1);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    src1 = 32'h7; src2 = 32'h9; start = 1'b1;
    @(negedge clk);
    start = 1'b0; src1 = 32'h11111111; src2 = 32'h22222222;
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if (busy1 !== (c <= 4) || done1 !== (c == 5)) begin
        errors++;
        $display("FAIL b2b_first c=%0d: got busy=%b done=%b, expected busy=%b done=%b", c, busy1, done1, c <= 4, c == 5);
      end
      if (c == 2) begin
        start = 1'b1; src1 = 32'h0000DEAD; src2 = 32'h0000BEEF;
      end else if (c == 5) begin
        start = 1'b1; src1 = 32'h10; src2 = 32'h10;
      end else begin
        start = 1'b0;
      end
      if (c < 5) @(negedge clk);
    end
    checks++;
    if (result1 !== 32'd63) begin
      errors++;
      $display("FAIL b2b_ignore_start: got result=%h, expected 0000003f", result1);
    end
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy1 !== (c <= 4) || done1 !== (c == 5) || result1 !== ((c == 5) ? 32'h100 : 32'd63)) begin
        errors++;
        $display("FAIL b2b_second c=%0d: got busy=%b done=%b result=%h, expected busy=%b done=%b result=%h",
                 c, busy1, done1, result1, c <= 4, c == 5, (c == 5) ? 32'h100 : 32'd63);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    src1 = 32'h00010002; src2 = 32'h00030004; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    src1 = 32'h00050006; src2 = 32'h00070008; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checks++;
    if ({busy1, done1, result1, busy2, done2, result2} !== 68'h0) begin
      errors++;
      $display("FAIL reset_mid: got l1 %b/%b/%h l2 %b/%b/%h, expected all zero", busy1, done1, result1, busy2, done2, result2);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if ({busy1, done1, result1, busy2, done2, result2} !== 68'h0) begin
        errors++;
        $display("FAIL reset_mid_after c=%0d: got l1 %b/%b/%h l2 %b/%b/%h, expected all zero", c, busy1, done1, result1, busy2, done2, result2);
      end
    end
  endtask

  task automatic test_random();
    logic [33:0] got, exp;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset_n = ($urandom_range(0, 199) != 0);
      start   = ($urandom_range(0, 2) == 0);
      stall   = ($urandom_range(0, 6) == 0);
      flush   = ($urandom_range(0, 39) == 0);
      src1    = rnd_op();
      src2    = rnd_op();
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        got = (i == 0) ? {busy1, done1, result1} : {busy2, done2, result2};
        exp = {(m_k[i] >= 1 && m_k[i] <= 3 + i + 1), (m_k[i] == 5 + i), m_res[i]};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL rand_l%0d cycle %0d: got busy=%b done=%b result=%h, expected busy=%b done=%b result=%h",
                   i + 1, n, got[33], got[32], got[31:0], exp[33], exp[32], exp[31:0]);
        end
      end
    end
    reset_n = 1'b1; start = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; stall = 1'b0; flush = 1'b0;
    src1 = 32'h0; src2 = 32'h0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_corners();
    test_stall();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
